srfpu_sr_convert: RTL and testbench
===================================

Name: srfpu_sr_convert

Overview:
PCPI coprocessor that narrows an FP32 operand to a reduced-precision float with 8-bit exponent and MANT_WIDTH-bit mantissa (bfloat16 by default). Rounding is selectable per instruction: round-to-nearest-even, round-toward-zero, or stochastic rounding driven by an internal reseedable LFSR. It sits on the same PCPI bus as the SRFPU core and serves as the conversion path for loading FP32 data into the SR format.

Parameters:
MANT_WIDTH, 7, mantissa bits of result; legal range 1..22.
NUM_ROUND_BITS, 20, random bits used for SR; effective count is min(NUM_ROUND_BITS, 23-MANT_WIDTH).
FUNCT7, 7'b0000101, funct7 value claimed by this unit.
LFSR_SEED, 32'hACE1_2468, LFSR reset value; must be nonzero.
NUM_BITS, 9+MANT_WIDTH, result width; derived, not overridable.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
pcpi_valid  in  1  instruction offered
pcpi_insn  in  32  instruction word
pcpi_rs1  in  32  FP32 operand or seed
pcpi_rs2  in  32  unused, ignored
pcpi_wr  out  1  write pcpi_rd to rd
pcpi_rd  out  32  result, zero-extended from NUM_BITS
pcpi_wait  out  1  instruction claimed, busy
pcpi_ready  out  1  completion pulse
state_test  out  2  FSM state encoding
rand_test  out  32  current LFSR value

Behaviour:
- Clock and reset: one clock clk. resetn is asynchronous and active-low.
- Reset values: FSM in IDLE; pcpi_wr, pcpi_wait, pcpi_ready = 0; pcpi_rd = 0; LFSR = LFSR_SEED.
- Decode: the unit claims an instruction when pcpi_insn[6:0] = 7'b0001011 and pcpi_insn[31:25] = FUNCT7 and funct3 = pcpi_insn[14:12] is in {000 RNE, 001 RTZ, 010 SR, 111 SEED}. For any other instruction all outputs stay 0.
- FSM states and encodings:
  - IDLE (0): on pcpi_valid with a claimed instruction, latch rs1 and funct3, assert pcpi_wait, and go to CALC. Also sample the LFSR in this cycle.
  - CALC (1): compute the result into pcpi_rd; pcpi_wait stays 1; go to DONE.
  - DONE (2): pcpi_ready = 1 and pcpi_wait = 0 for exactly one cycle. pcpi_wr = 1 for convert ops and 0 for SEED. Go to HOLD.
  - HOLD (3): remain until pcpi_valid = 0, then return to IDLE. This prevents re-issue of the same instruction.
- Latency: pcpi_ready asserts 2 cycles after the claim cycle.
- LFSR: 32-bit Galois, taps 0x80200003, advances every cycle in all states.
  - SEED loads rs1 in the CALC cycle, which overrides advancement in that cycle.
  - A seed of 0 loads LFSR_SEED instead.
- Conversion: sign is passed through. Let D = 23-MANT_WIDTH, kept = rs1[22:D], dropped = rs1[D-1:0].
  - RTZ: result = {sign, exp, kept}.
  - RNE: increment when dropped > half, or when dropped = half and the LSB of kept is 1.
  - SR: increment when the carry-out of (top R bits of dropped) + (LFSR[R-1:0]) is 1, where R = min(NUM_ROUND_BITS, D). The LFSR value used is the one sampled in the IDLE claim cycle.
  - Increment is applied to {exp, kept} as one unsigned field. A carry into exponent 0xFF yields ±Inf with mantissa 0. This covers overflow and the subnormal-to-normal transition.
  - Special inputs (override all modes):
    - Input exp = 0xFF with mantissa 0: ±Inf.
    - Input exp = 0xFF with mantissa nonzero: canonical qNaN {0, 0xFF, 1, 0...}.
    - Zero and subnormal inputs follow the normal rules; there is no flush.
- Reset during CALC, DONE or HOLD: immediate return to IDLE with all outputs at reset values and LFSR reseeded. No pcpi_ready is issued for the aborted instruction.
- pcpi_valid dropped in CALC: the operation still completes through DONE; HOLD then exits on the next cycle.

Test Plan:
- RNE with MANT_WIDTH=7: rs1 = 0x3F800000 -> pcpi_rd = 0x00003F80, pcpi_ready 2 cycles after the claim, single-cycle pulse.
- RNE ties: 0x3F808000 -> 0x3F80; 0x3F818000 -> 0x3F82; 0x3F808001 -> 0x3F81.
- RTZ and overflow: RTZ 0x3F80FFFF -> 0x3F80. RNE 0x7F7FFFFF -> 0x7F80. RNE 0xFF800000 -> 0xFF80. 0x7FC00001 -> 0x7FC0 under all modes.
- Stochastic rounding: SEED with rs1 = 0 (loads LFSR_SEED), then 1024 SR ops on 0x3F804000 -> result is only 0x3F80 or 0x3F81, and the round-up count is within 256±64. Repeating after reseed reproduces an identical result sequence.
- Decode and handshake: funct7 mismatch or funct3 = 011 -> no pcpi_wait or pcpi_ready. pcpi_valid held high for 5 cycles after ready -> no second ready. SEED -> pcpi_ready = 1 with pcpi_wr = 0.
- Reset mid-op: resetn low during CALC -> all outputs 0 immediately, no ready pulse, rand_test = LFSR_SEED.

Source files
------------

// File: rtl/srfpu_sr_convert_if.sv
// PCPI bus bundle shared by the CPU (master) and the FP32 -> SR format converter (slave).
interface srfpu_sr_convert_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/srfpu_sr_convert.sv
// PCPI coprocessor narrowing FP32 to an 8-bit-exponent / MANT_WIDTH-bit-mantissa float
// with RNE, RTZ or stochastic rounding from a reseedable 32-bit Galois LFSR.
module srfpu_sr_convert #(
    parameter int          MANT_WIDTH     = 7,
    parameter int          NUM_ROUND_BITS = 20,
    parameter logic [6:0]  FUNCT7         = 7'b0000101,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2468
) (
    input  logic               clk,
    input  logic               resetn,
    srfpu_sr_convert_if.slave  bus,
    output logic [1:0]         state_test,
    output logic [31:0]        rand_test
);
    localparam int NUM_BITS = 9 + MANT_WIDTH;
    localparam int MAG_BITS = 8 + MANT_WIDTH;
    localparam int D        = 23 - MANT_WIDTH;
    localparam int R        = (NUM_ROUND_BITS < D) ? NUM_ROUND_BITS : D;

    localparam logic [31:0]           TAPS     = 32'h8020_0003;
    localparam logic [D-1:0]          HALF     = D'(1) << (D - 1);
    localparam logic [MANT_WIDTH-1:0] NAN_MANT = MANT_WIDTH'(1) << (MANT_WIDTH - 1);

    localparam logic [2:0] OP_RNE  = 3'b000;
    localparam logic [2:0] OP_RTZ  = 3'b001;
    localparam logic [2:0] OP_SR   = 3'b010;
    localparam logic [2:0] OP_SEED = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state, next_state;
    logic   take;

    logic [31:0]         lfsr, lfsr_next;
    logic [31:0]         rs1_q;
    logic [2:0]          op_q;
    logic [R-1:0]        rand_q;
    logic [NUM_BITS-1:0] result_q;

    logic [2:0] funct3;
    logic       op_ok;
    logic       claim;
    logic       unused_bits;

    assign funct3 = bus.pcpi_insn[14:12];
    assign op_ok  = (funct3 == OP_RNE) || (funct3 == OP_RTZ) ||
                    (funct3 == OP_SR)  || (funct3 == OP_SEED);
    assign claim  = bus.pcpi_valid && (bus.pcpi_insn[6:0] == 7'b0001011) &&
                    (bus.pcpi_insn[31:25] == FUNCT7) && op_ok;

    assign unused_bits = ^{bus.pcpi_rs2, bus.pcpi_insn[24:15], bus.pcpi_insn[11:7]};

    // Handshake: a claim is taken on a clock edge that sees pcpi_valid with a matching
    // insn in IDLE; pcpi_wait is high in CALC, pcpi_ready pulses for one cycle in DONE
    // (with pcpi_rd valid only then), and HOLD waits for pcpi_valid low before re-arming.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state     = state;
        take           = 1'b0;
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (claim) begin
                    take       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                bus.pcpi_wait = 1'b1;
                next_state    = DONE;
            end
            DONE: begin
                bus.pcpi_ready = 1'b1;
                bus.pcpi_wr    = (op_q != OP_SEED);
                next_state     = HOLD;
            end
            HOLD: begin
                if (!bus.pcpi_valid) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.pcpi_rd = (state == DONE) ? 32'(result_q) : 32'd0;
    assign state_test  = state;
    assign rand_test   = lfsr;

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

    logic                  sign_in;
    logic [7:0]            exp_in;
    logic [MANT_WIDTH-1:0] kept;
    logic [D-1:0]          dropped;
    logic [R-1:0]          top_bits;
    logic [R:0]            sr_sum;
    logic                  round_up;
    logic [MAG_BITS-1:0]   mag;
    logic [NUM_BITS-1:0]   conv;

    always_comb begin
        sign_in  = rs1_q[31];
        exp_in   = rs1_q[30:23];
        kept     = rs1_q[22:D];
        dropped  = rs1_q[D-1:0];
        top_bits = dropped[D-1 -: R];
        sr_sum   = {1'b0, top_bits} + {1'b0, rand_q};
        round_up = 1'b0;
        case (op_q)
            OP_RNE:  round_up = (dropped > HALF) || ((dropped == HALF) && kept[0]);
            OP_SR:   round_up = sr_sum[R];
            default: round_up = 1'b0;
        endcase
        // A carry out of the mantissa lands in the exponent; reaching 0xFF gives Inf.
        mag = {exp_in, kept} + MAG_BITS'(round_up);
        if (exp_in == 8'hFF) begin
            if (rs1_q[22:0] == 23'd0) conv = {sign_in, 8'hFF, {MANT_WIDTH{1'b0}}};
            else                      conv = {1'b0, 8'hFF, NAN_MANT};
        end else begin
            conv = {sign_in, mag};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr     <= LFSR_SEED;
            rs1_q    <= 32'd0;
            op_q     <= 3'd0;
            rand_q   <= '0;
            result_q <= '0;
        end else begin
            lfsr <= lfsr_next;
            if (take) begin
                rs1_q  <= bus.pcpi_rs1;
                op_q   <= funct3;
                rand_q <= lfsr[R-1:0];
            end
            if (state == CALC) begin
                if (op_q == OP_SEED) begin
                    lfsr     <= (rs1_q == 32'd0) ? LFSR_SEED : rs1_q;
                    result_q <= '0;
                end else begin
                    result_q <= conv;
                end
            end
        end
    end
endmodule

// File: tb/tb_srfpu_sr_convert.sv
// Randomised bench for srfpu_sr_convert: arithmetic reference model, step-counted LFSR
// model, directed rounding corners, decode/handshake and reset-abort checks.
module tb_srfpu_sr_convert;
    localparam int          MW    = 7;
    localparam int          NRB   = 20;
    localparam logic [6:0]  F7    = 7'b0000101;
    localparam logic [31:0] SEED0 = 32'hACE1_2468;

    localparam logic [2:0] OP_RNE  = 3'b000;
    localparam logic [2:0] OP_RTZ  = 3'b001;
    localparam logic [2:0] OP_SR   = 3'b010;
    localparam logic [2:0] OP_SEED = 3'b111;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  state_test;
    logic [31:0] rand_test;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_lfsr;
    int          m_edge;
    logic [31:0] seq1[1024];

    srfpu_sr_convert_if bus();

    srfpu_sr_convert #(
        .MANT_WIDTH(MW),
        .NUM_ROUND_BITS(NRB),
        .FUNCT7(F7),
        .LFSR_SEED(SEED0)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus),
        .state_test(state_test),
        .rand_test(rand_test)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v / 2) ^ ((v % 2 == 1) ? 32'h8020_0003 : 32'h0);
    endfunction

    // Value the DUT LFSR holds right after edge number edge_n.
    task automatic lfsr_at(input int edge_n, output logic [31:0] v);
        while (m_edge < edge_n) begin
            m_lfsr = lfsr_step(m_lfsr);
            m_edge++;
        end
        v = m_lfsr;
    endtask

    function automatic logic [31:0] ref_conv(input logic [2:0] f3, input logic [31:0] x,
                                             input logic [31:0] rnd);
        longint unsigned d     = 23 - MW;
        longint unsigned rb    = (NRB < 23 - MW) ? NRB : 23 - MW;
        longint unsigned field = {33'd0, x[30:0]} >> d;
        longint unsigned rem   = {41'd0, x[22:0]} % (64'd1 << d);
        longint unsigned half  = 64'd1 << (d - 1);
        longint unsigned top   = rem >> (d - rb);
        longint unsigned r     = {32'd0, rnd} % (64'd1 << rb);
        longint unsigned sgn   = {63'd0, x[31]} << (8 + MW);
        longint unsigned up    = 0;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) return 32'(sgn | (64'hFF << MW));
            return 32'((64'hFF << MW) | (64'd1 << (MW - 1)));
        end
        if (f3 == OP_RNE)
            up = (rem > half || (rem == half && field % 2 == 1)) ? 1 : 0;
        else if (f3 == OP_SR)
            up = (top + r >= (64'd1 << rb)) ? 1 : 0;
        return 32'(sgn + field + up);
    endfunction

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0001011};
    endfunction

    task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] rs1,
                          input int hold, output logic [31:0] rd, output logic wr,
                          output int lat, output int claim_n, output int extra,
                          output logic [31:0] rt);
        @(negedge clk);
        bus.pcpi_insn  = mk_insn(f7, f3);
        bus.pcpi_rs1   = rs1;
        bus.pcpi_rs2   = $urandom;
        bus.pcpi_valid = 1'b1;
        claim_n = cyc;
        lat     = -1;
        rd      = 32'd0;
        wr      = 1'b0;
        extra   = 0;
        rt      = 32'd0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.pcpi_ready) begin
                lat = i;
                rd  = bus.pcpi_rd;
                wr  = bus.pcpi_wr;
                rt  = rand_test;
                break;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.pcpi_ready) extra++;
        end
        bus.pcpi_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_seed(input logic [31:0] s, input int hold, input string tag);
        logic [31:0] rd, rt, want;
        logic        wr;
        int          lat, cn, extra;
        run_op(F7, OP_SEED, s, hold, rd, wr, lat, cn, extra, rt);
        want   = (s == 32'd0) ? SEED0 : s;
        m_lfsr = want;
        m_edge = cn + 2;
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_wr"}, {31'd0, wr}, 32'd0);
        check({tag, "_lfsr"}, rt, want);
        if (hold > 0) check({tag, "_extra_ready"}, 32'(extra), 32'd0);
    endtask

    task automatic do_conv(input logic [2:0] f3, input logic [31:0] rs1, input string tag,
                           output logic [31:0] rd);
        logic [31:0] rt, rnd;
        logic        wr;
        int          lat, cn, extra;
        run_op(F7, f3, rs1, 0, rd, wr, lat, cn, extra, rt);
        rnd = 32'd0;
        if (f3 == OP_SR) lfsr_at(cn, rnd);
        exp_q.push_back(ref_conv(f3, rs1, rnd));
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_wr"}, {31'd0, wr}, 32'd1);
        check(tag, rd, exp_q.pop_front());
    endtask

    task automatic bad_insn(input logic [6:0] f7, input logic [2:0] f3, input string tag);
        logic seen;
        @(negedge clk);
        bus.pcpi_insn  = mk_insn(f7, f3);
        bus.pcpi_rs1   = $urandom;
        bus.pcpi_valid = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | bus.pcpi_wait | bus.pcpi_ready | bus.pcpi_wr | (bus.pcpi_rd != 32'd0);
        end
        check(tag, {31'd0, seen}, 32'd0);
        bus.pcpi_valid = 1'b0;
    endtask

    logic [2:0]  dir_op[10]  = '{OP_RNE, OP_RNE, OP_RNE, OP_RNE, OP_RTZ,
                                 OP_RNE, OP_RNE, OP_RNE, OP_RTZ, OP_SR};
    logic [31:0] dir_in[10]  = '{32'h3F80_0000, 32'h3F80_8000, 32'h3F81_8000, 32'h3F80_8001,
                                 32'h3F80_FFFF, 32'h7F7F_FFFF, 32'hFF80_0000, 32'h7FC0_0001,
                                 32'h7FC0_0001, 32'h7FC0_0001};
    logic [31:0] dir_exp[10] = '{32'h3F80, 32'h3F80, 32'h3F82, 32'h3F81, 32'h3F80,
                                 32'h7F80, 32'hFF80, 32'h7FC0, 32'h7FC0, 32'h7FC0};

    initial begin
        logic [31:0] rd, x;
        logic [2:0]  f3;
        int          ups, bad, diffs;
        logic        saw_ready;

        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = 32'd0;
        bus.pcpi_rs1   = 32'd0;
        bus.pcpi_rs2   = 32'd0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_wait", {31'd0, bus.pcpi_wait}, 32'd0);
        check("rst_ready", {31'd0, bus.pcpi_ready}, 32'd0);
        check("rst_wr", {31'd0, bus.pcpi_wr}, 32'd0);
        check("rst_rd", bus.pcpi_rd, 32'd0);
        check("rst_state", {30'd0, state_test}, 32'd0);
        check("rst_lfsr", rand_test, SEED0);
        resetn = 1'b1;

        // directed rounding corners
        for (int i = 0; i < 10; i++) begin
            if (dir_op[i] == OP_SR) do_seed(32'd0, 0, "dir_seed");
            do_conv(dir_op[i], dir_in[i], "dir_model", rd);
            check("dir_const", rd, dir_exp[i]);
        end

        // decode rejection and hold-off after ready
        bad_insn(F7 ^ 7'h01, OP_RNE, "dec_funct7");
        bad_insn(F7, 3'b011, "dec_funct3_011");
        bad_insn(F7, 3'b100, "dec_funct3_100");
        do_seed(32'h1234_5678, 5, "seed_hold");

        // stochastic rounding statistics and reproducibility
        do_seed(32'd0, 0, "sr_seed_a");
        ups = 0;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            do_conv(OP_SR, 32'h3F80_4000, "sr_a", rd);
            seq1[i] = rd;
            if (rd == 32'h3F81) ups++;
            else if (rd != 32'h3F80) bad++;
        end
        check("sr_out_of_set", 32'(bad), 32'd0);
        check("sr_up_window", {31'd0, (ups >= 192 && ups <= 320)}, 32'd1);
        do_seed(32'd0, 0, "sr_seed_b");
        diffs = 0;
        for (int i = 0; i < 1024; i++) begin
            do_conv(OP_SR, 32'h3F80_4000, "sr_b", rd);
            if (rd != seq1[i]) diffs++;
        end
        check("sr_repeat_diffs", 32'(diffs), 32'd0);

        // random mixed operands
        do_seed($urandom, 0, "rand_seed");
        for (int i = 0; i < 300; i++) begin
            x = $urandom;
            case ($urandom_range(0, 5))
                0: x[30:23] = 8'hFF;
                1: x[30:23] = 8'h00;
                2: x[30:23] = 8'hFE;
                3: x[15:0]  = 16'h8000;
                default: ;
            endcase
            case ($urandom_range(0, 2))
                0:       f3 = OP_RNE;
                1:       f3 = OP_RTZ;
                default: f3 = OP_SR;
            endcase
            do_conv(f3, x, "rand", rd);
        end

        // reset while in CALC
        @(negedge clk);
        bus.pcpi_insn  = mk_insn(F7, OP_SR);
        bus.pcpi_rs1   = 32'h3F80_4000;
        bus.pcpi_valid = 1'b1;
        @(negedge clk);
        check("mid_wait", {31'd0, bus.pcpi_wait}, 32'd1);
        check("mid_state", {30'd0, state_test}, 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_wait", {31'd0, bus.pcpi_wait}, 32'd0);
        check("abort_ready", {31'd0, bus.pcpi_ready}, 32'd0);
        check("abort_wr", {31'd0, bus.pcpi_wr}, 32'd0);
        check("abort_rd", bus.pcpi_rd, 32'd0);
        check("abort_state", {30'd0, state_test}, 32'd0);
        check("abort_lfsr", rand_test, SEED0);
        saw_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_ready = saw_ready | bus.pcpi_ready;
        end
        bus.pcpi_valid = 1'b0;
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            saw_ready = saw_ready | bus.pcpi_ready;
        end
        check("abort_no_ready", {31'd0, saw_ready}, 32'd0);
        do_conv(OP_RTZ, 32'hBF80_FFFF, "post_abort", rd);
        check("post_abort_const", rd, 32'hBF80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
